// File: rtl/pix2axis_if.sv
// rtl/pix2axis_if.sv - pixel input and packed AXI-Stream output bundle for pix2axis
interface pix2axis_if;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    // Producer/consumer view: drives pixels and accepts packed words
    modport master (
        output pix_in, pix_valid, m_axis_tready,
        input  pix_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );

    // Block view: consumes pixels and emits packed words
    modport slave (
        input  pix_in, pix_valid, m_axis_tready,
        output pix_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/pix2axis.sv
// rtl/pix2axis.sv - packs 8-bit gray pixels into 32-bit AXI-Stream words with line/frame framing
module pix2axis #(
    parameter int LINE_WIDTH = 1024,
    parameter int LINES      = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soft_clr,
    pix2axis_if.slave  bus,
    output logic       frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Word FIFO storage; occupancy has one extra bit so "full" is representable
    logic [31:0] mem_data [FIFO_DEPTH];
    logic [3:0]  mem_keep [FIFO_DEPTH];
    logic        mem_last [FIFO_DEPTH];
    logic        mem_fend [FIFO_DEPTH];
    logic [AW:0]   occ;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Packer state: lanes 0..2 are held here; lane 3 always completes a word
    logic [1:0]  lane;
    logic [23:0] part;
    logic [10:0] col;
    logic [11:0] line;

    logic        accept;
    logic        push;
    logic        pop;
    logic        last_col;
    logic        last_line;
    logic [31:0] new_word;
    logic [3:0]  new_keep;

    // Ready comes straight from registered occupancy; held low during reset and flush
    assign bus.pix_ready = rst_n && !soft_clr && (occ < (AW+1)'(FIFO_DEPTH));

    // Output side shows the FIFO head whenever it is non-empty, zeros otherwise
    assign bus.m_axis_tvalid = (occ != '0);
    assign bus.m_axis_tdata  = bus.m_axis_tvalid ? mem_data[rd_ptr] : 32'h0;
    assign bus.m_axis_tkeep  = bus.m_axis_tvalid ? mem_keep[rd_ptr] : 4'h0;
    assign bus.m_axis_tlast  = bus.m_axis_tvalid ? mem_last[rd_ptr] : 1'b0;

    // Handshake decode and assembly of the word a completing pixel would push
    always_comb begin
        accept    = bus.pix_valid && bus.pix_ready;
        pop       = bus.m_axis_tvalid && bus.m_axis_tready;
        last_col  = (col == 11'(LINE_WIDTH - 1));
        last_line = (line == 12'(LINES - 1));
        push      = accept && ((lane == 2'd3) || last_col);
        new_word  = 32'h0;
        new_keep  = 4'h0;
        case (lane)
            2'd0: begin
                new_word = {24'h0, bus.pix_in};
                new_keep = 4'b0001;
            end
            2'd1: begin
                new_word = {16'h0, bus.pix_in, part[7:0]};
                new_keep = 4'b0011;
            end
            2'd2: begin
                new_word = {8'h0, bus.pix_in, part[15:0]};
                new_keep = 4'b0111;
            end
            default: begin
                new_word = {bus.pix_in, part};
                new_keep = 4'b1111;
            end
        endcase
    end

    // FIFO payload write; entries are only ever read while occupancy covers them
    always_ff @(posedge clk) begin
        if (push && !soft_clr) begin
            mem_data[wr_ptr] <= new_word;
            mem_keep[wr_ptr] <= new_keep;
            mem_last[wr_ptr] <= last_col;
            mem_fend[wr_ptr] <= last_col && last_line;
        end
    end

    // Control state: packer, position counters, FIFO pointers and frame_done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lane       <= 2'd0;
            part       <= 24'h0;
            col        <= 11'd0;
            line       <= 12'd0;
            frame_done <= 1'b0;
        end else if (soft_clr) begin
            occ        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lane       <= 2'd0;
            part       <= 24'h0;
            col        <= 11'd0;
            line       <= 12'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && mem_fend[rd_ptr];
            if (accept) begin
                if (push) begin
                    lane <= 2'd0;
                    part <= 24'h0;
                end else begin
                    lane <= lane + 2'd1;
                    case (lane)
                        2'd0:    part[7:0]   <= bus.pix_in;
                        2'd1:    part[15:8]  <= bus.pix_in;
                        default: part[23:16] <= bus.pix_in;
                    endcase
                end
                if (last_col) begin
                    col  <= 11'd0;
                    line <= last_line ? 12'd0 : line + 12'd1;
                end else begin
                    col <= col + 11'd1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_pix2axis.sv
// tb/tb_pix2axis.sv - scoreboard bench for pix2axis
module tb_pix2axis;

    localparam int LW = 6;
    localparam int LN = 2;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic soft_clr = 1'b0;
    logic frame_done;

    pix2axis_if bus();

    pix2axis #(.LINE_WIDTH(LW), .LINES(LN), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .soft_clr   (soft_clr),
        .bus        (bus.slave),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        f;
    } exp_t;

    exp_t sb[$];
    logic exp_fd = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l, input logic f);
        exp_t e;
        e.d = d; e.k = k; e.l = l; e.f = f;
        sb.push_back(e);
    endtask

    // Monitor: compares every handshaken word against the scoreboard and tracks frame_done
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_fd = 1'b0;
        end else begin
            if (frame_done || exp_fd) chk("frame_done", 32'(frame_done), 32'(exp_fd));
            exp_fd = 1'b0;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h expected none", bus.m_axis_tdata);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", bus.m_axis_tdata, e.d);
                    chk("tkeep", 32'(bus.m_axis_tkeep), 32'(e.k));
                    chk("tlast", 32'(bus.m_axis_tlast), 32'(e.l));
                    exp_fd = e.f;
                end
            end
        end
    end

    task automatic send(input logic [7:0] p);
        int t;
        t = 0;
        bus.pix_in = p;
        bus.pix_valid = 1'b1;
        @(negedge clk);
        while (!bus.pix_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.pix_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL pix_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send(first + 8'(i));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.m_axis_tvalid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_in = 8'h00;
        bus.pix_valid = 1'b0;
        bus.m_axis_tready = 1'b0;

        // Reset state
        #2;
        chk("ready_in_reset", 32'(bus.pix_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(bus.pix_ready), 32'd1);
        chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_tdata", bus.m_axis_tdata, 32'd0);
        chk("rst_tkeep", 32'(bus.m_axis_tkeep), 32'd0);
        chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // Full frame, free-flowing output, short line tail word, latency
        @(posedge clk); #1;
        bus.m_axis_tready = 1'b1;
        expect_word(32'hA3A2A1A0, 4'hF, 1'b0, 1'b0);
        expect_word(32'h0000A5A4, 4'h3, 1'b1, 1'b0);
        expect_word(32'hA9A8A7A6, 4'hF, 1'b0, 1'b0);
        expect_word(32'h0000ABAA, 4'h3, 1'b1, 1'b1);
        send_range(8'hA0, 3);
        chk("tvalid_before_word", 32'(bus.m_axis_tvalid), 32'd0);
        send(8'hA3);
        chk("tvalid_latency", 32'(bus.m_axis_tvalid), 32'd1);
        send_range(8'hA4, 8);
        wait_drain();

        // Backpressure fills the FIFO, head holds, then drains in order
        @(posedge clk); #1;
        bus.m_axis_tready = 1'b0;
        expect_word(32'hB3B2B1B0, 4'hF, 1'b0, 1'b0);
        expect_word(32'h0000B5B4, 4'h3, 1'b1, 1'b0);
        expect_word(32'hB9B8B7B6, 4'hF, 1'b0, 1'b0);
        expect_word(32'h0000BBBA, 4'h3, 1'b1, 1'b1);
        send_range(8'hB0, 12);
        @(negedge clk);
        chk("full_ready", 32'(bus.pix_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_tdata", bus.m_axis_tdata, 32'hB3B2B1B0);
        end
        @(posedge clk); #1;
        bus.m_axis_tready = 1'b1;
        expect_word(32'hBFBEBDBC, 4'hF, 1'b0, 1'b0);
        expect_word(32'h0000C1C0, 4'h3, 1'b1, 1'b0);
        send_range(8'hBC, 4);
        send_range(8'hC0, 2);
        wait_drain();
        chk("ready_back", 32'(bus.pix_ready), 32'd1);

        // soft_clr mid-word, mid-frame: partial discarded, counters restart
        send_range(8'hD0, 2);
        @(posedge clk); #1;
        soft_clr = 1'b1;
        @(negedge clk);
        chk("ready_in_clr", 32'(bus.pix_ready), 32'd0);
        @(posedge clk); #1;
        soft_clr = 1'b0;
        chk("clr_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        expect_word(32'hE3E2E1E0, 4'hF, 1'b0, 1'b0);
        expect_word(32'h0000E5E4, 4'h3, 1'b1, 1'b0);
        expect_word(32'hF3F2F1F0, 4'hF, 1'b0, 1'b0);
        expect_word(32'h0000F5F4, 4'h3, 1'b1, 1'b1);
        send_range(8'hE0, 6);
        send_range(8'hF0, 6);
        wait_drain();

        // Async reset mid-frame with a word waiting
        @(posedge clk); #1;
        bus.m_axis_tready = 1'b0;
        send_range(8'h10, 5);
        @(negedge clk);
        chk("pre_rst_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("arst_tdata", bus.m_axis_tdata, 32'd0);
        chk("arst_tkeep", 32'(bus.m_axis_tkeep), 32'd0);
        chk("arst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        chk("arst_ready", 32'(bus.pix_ready), 32'd0);
        chk("arst_frame_done", 32'(frame_done), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.m_axis_tready = 1'b1;
        expect_word(32'h23222120, 4'hF, 1'b0, 1'b0);
        expect_word(32'h00002524, 4'h3, 1'b1, 1'b0);
        expect_word(32'h29282726, 4'hF, 1'b0, 1'b0);
        expect_word(32'h00002B2A, 4'h3, 1'b1, 1'b1);
        send_range(8'h20, 12);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pix2axis.md
PIX2AXIS -- requirements
Module: pix2axis

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 1024, pixels per line (range 1..2047).
REQ-002 SHALL have parameter LINES, default 1024, lines per frame (range 1..4095).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO entries (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port soft_clr, input, 1, synchronous flush of the packer, counters and FIFO.
REQ-007 SHALL have port pix_in, input, 8, gray pixel from the filter stage.
REQ-008 SHALL have port pix_valid, input, 1, pix_in is valid this cycle.
REQ-009 SHALL have port pix_ready, output, 1, block accepts a pixel this cycle.
REQ-010 SHALL have port m_axis_tdata, output, 32, packed pixels.
REQ-011 SHALL have port m_axis_tkeep, output, 4, byte enables.
REQ-012 SHALL have port m_axis_tvalid, output, 1, output word valid.
REQ-013 SHALL have port m_axis_tlast, output, 1, last word of a line.
REQ-014 SHALL have port m_axis_tready, input, 1, downstream accepts a word.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse when a frame has fully left the block.

Function
REQ-016 SHALL accept a pixel only when pix_valid and pix_ready are both 1 (accept event).
REQ-017 SHALL drive pix_ready = 1 only when the FIFO occupancy, taken from a registered count, is below FIFO_DEPTH and soft_clr is 0.
REQ-018 SHALL pack pixels little-endian: byte lane 0 is tdata[7:0] and takes the first pixel of the word; lanes fill in ascending order.
REQ-019 SHALL push a word into the FIFO on the accept event that fills lane 3 or that carries the last pixel of a line (column == LINE_WIDTH-1), whichever comes first.
REQ-020 SHALL set tkeep to one bit per filled lane, for example 4'b0001, 4'b0011, 4'b0111 or 4'b1111; unfilled lanes SHALL be 0x00.
REQ-021 SHALL store tlast = 1 with the word that holds the last pixel of a line; a new line SHALL always start at lane 0.
REQ-022 SHALL store a frame-end flag with the word that holds the last pixel of line LINES-1.
REQ-023 SHALL keep a column counter that wraps LINE_WIDTH-1 -> 0 and a line counter that advances on each column wrap and wraps LINES-1 -> 0.
REQ-024 SHALL raise m_axis_tvalid exactly 1 cycle after the push edge when the FIFO was empty; latency from the completing pixel accept to tvalid is 1 cycle.
REQ-025 SHALL present the FIFO head on tdata, tkeep and tlast, and SHALL hold it stable while tvalid=1 and tready=0.
REQ-026 SHALL pop the FIFO on tvalid && tready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-027 SHALL never push while the FIFO is full (guaranteed by REQ-017) and never pop while it is empty (tvalid=0).
REQ-028 SHALL pulse frame_done for 1 cycle, in the cycle after the pop of the word carrying the frame-end flag.
REQ-029 SHALL, on soft_clr=1, clear the occupancy, the lane index, the partial word, both counters and tvalid at the next edge, discarding any pending data.
REQ-030 SHALL, when soft_clr coincides with an accept, pop or push, let soft_clr win, drop the pixel and not pulse frame_done.
REQ-031 SHALL size the internal counters at 11 bits for column, 12 bits for line and log2(FIFO_DEPTH)+1 bits for occupancy, with no overflow for the legal parameter ranges.

Reset
REQ-032 SHALL, on rst_n=0, asynchronously clear tvalid, tlast, tkeep, tdata, frame_done, the occupancy count, the lane index, the column counter and the line counter to 0.
REQ-033 SHALL drive pix_ready=0 while rst_n=0 and SHALL assert pix_ready=1 in the first cycle after release.
REQ-034 SHALL restart at column 0, line 0, lane 0 after reset is asserted in the middle of a frame, with no residual words output.

Verification
REQ-035 SHALL pass: with LINE_WIDTH=8, pixels 0x01..0x08 sent and tready=1 -> words 0x04030201 and 0x08070605, tkeep=4'hF, tlast on the second word only.
REQ-036 SHALL pass: with LINE_WIDTH=6, pixels 0xA0..0xA5 sent -> words 0xA3A2A1A0 (tkeep F, tlast 0) and 0x0000A5A4 (tkeep 3, tlast 1).
REQ-037 SHALL pass: with tready=0 and FIFO_DEPTH=4, 16 pixels sent -> pix_ready falls after the 4th word is pushed and tdata stays stable; raising tready drains the 4 words in order and pix_ready returns to 1.
REQ-038 SHALL pass: with LINE_WIDTH=4 and LINES=2, 8 pixels sent -> exactly one frame_done pulse, in the cycle after the second tlast handshake.
REQ-039 SHALL pass: soft_clr asserted after 2 pixels of a word -> no word output; the next 4 pixels form a word starting at lane 0.
REQ-040 SHALL pass: rst_n pulsed low during a frame with tvalid=1 -> all outputs 0 asynchronously; the frame then restarts correctly.
